// File: rtl/aes_bist_engine.sv
// LFSR-driven BIST for the AES core with MISR compaction; transparent mux in functional mode. Optional drain watchdog under BIST_TIMEOUT_EN.
// Mux paths are combinational; a run takes 2 + NUM_PATTERNS cycles plus drain, and the engine never backpressures the core.
module aes_bist_engine #(
   parameter int               WIDTH          = 8,
   parameter logic [WIDTH-1:0] KEY_TAPS       = 8'h63,
   parameter logic [WIDTH-1:0] DATA_TAPS      = 8'h63,
   parameter logic [WIDTH-1:0] MISR_TAPS      = 8'h63,
   parameter logic [WIDTH-1:0] KEY_SEED       = 8'hA5,
   parameter logic [WIDTH-1:0] DATA_SEED      = 8'h0F,
   parameter int               NUM_PATTERNS   = 16,
   parameter logic [WIDTH-1:0] GOLDEN_SIG     = 8'hC0,
   parameter int               TIMEOUT_CYCLES = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             is_bist,
   input  logic             bist_start,
   input  logic             bist_abort,
   input  logic [WIDTH-1:0] key_in,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] key_to_dut,
   output logic [WIDTH-1:0] data_to_dut,
   input  logic [WIDTH-1:0] dut_dout,
   input  logic             dut_vld,
   input  logic             dut_done,
   output logic [WIDTH-1:0] d_out,
   output logic             bist_busy,
   output logic             bist_done,
   output logic             bist_pass,
   output logic             bist_timeout,
   output logic [WIDTH-1:0] signature
);

   localparam int               CW        = $clog2(NUM_PATTERNS + 1);
   localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [WIDTH-1:0] KEY_INIT  = (KEY_SEED == '0) ? ONE : KEY_SEED;
   localparam logic [WIDTH-1:0] DATA_INIT = (DATA_SEED == '0) ? ONE : DATA_SEED;
   localparam logic [CW-1:0]    CNT_LAST  = CW'(NUM_PATTERNS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEED,
      S_DRIVE,
      S_DRAIN,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] key_q, key_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] sig_q, sig_d;
   logic             start_q;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [WIDTH-1:0] key_step, data_step, sig_step;
   logic             start_rise, abort;

`ifdef BIST_TIMEOUT_EN
   localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          tmo_hit_q, tmo_hit_d;
   logic          tmo_q, tmo_d;
`endif

   assign key_step   = {key_q[WIDTH-2:0], ^(key_q & KEY_TAPS)};
   assign data_step  = {data_q[WIDTH-2:0], ^(data_q & DATA_TAPS)};
   assign sig_step   = {sig_q[WIDTH-2:0], ^(sig_q & MISR_TAPS)} ^ dut_dout;
   assign start_rise = bist_start & ~start_q;
   assign abort      = bist_abort | ~is_bist;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      data_d  = data_q;
      sig_d   = sig_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
`ifdef BIST_TIMEOUT_EN
      tmo_cnt_d = tmo_cnt_q;
      tmo_hit_d = tmo_hit_q;
      tmo_d     = tmo_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (is_bist && start_rise) state_d = S_SEED;
         end
         S_SEED: begin
            key_d   = KEY_INIT;
            data_d  = DATA_INIT;
            sig_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
`ifdef BIST_TIMEOUT_EN
            tmo_cnt_d = '0;
            tmo_hit_d = 1'b0;
            tmo_d     = 1'b0;
`endif
            state_d = S_DRIVE;
         end
         S_DRIVE: begin
            key_d  = key_step;
            data_d = data_step;
            cnt_d  = cnt_q + 1'b1;
            if (dut_vld) sig_d = sig_step;
            if (cnt_q == CNT_LAST) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (dut_vld) sig_d = sig_step;
            if (dut_done) begin
               state_d = S_COMPARE;
`ifdef BIST_TIMEOUT_EN
            end else if (tmo_cnt_q == TMO_LAST) begin
               tmo_hit_d = 1'b1;
               state_d   = S_COMPARE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
            end
         end
         S_COMPARE: begin
            // The last word (vld with done) was folded in on the DRAIN exit edge.
`ifdef BIST_TIMEOUT_EN
            pass_d = (sig_q == GOLDEN_SIG) & ~tmo_hit_q;
            tmo_d  = tmo_hit_q;
`else
            pass_d = (sig_q == GOLDEN_SIG);
`endif
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (!bist_start) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (state_q != S_IDLE && abort) begin
         state_d = S_IDLE;
         cnt_d   = cnt_q;
         key_d   = key_q;
         data_d  = data_q;
         sig_d   = sig_q;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         pass_d  = 1'b0;
`ifdef BIST_TIMEOUT_EN
         tmo_d   = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         key_q   <= KEY_INIT;
         data_q  <= DATA_INIT;
         sig_q   <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
`ifdef BIST_TIMEOUT_EN
         tmo_cnt_q <= '0;
         tmo_hit_q <= 1'b0;
         tmo_q     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         data_q  <= data_d;
         sig_q   <= sig_d;
         start_q <= bist_start;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
`ifdef BIST_TIMEOUT_EN
         tmo_cnt_q <= tmo_cnt_d;
         tmo_hit_q <= tmo_hit_d;
         tmo_q     <= tmo_d;
`endif
      end
   end

   assign key_to_dut  = is_bist ? key_q : key_in;
   assign data_to_dut = is_bist ? data_q : d_in;
   assign d_out       = is_bist ? sig_q : dut_dout;
   assign signature   = sig_q;
   assign bist_busy   = busy_q;
   assign bist_done   = done_q;
   assign bist_pass   = pass_q;
`ifdef BIST_TIMEOUT_EN
   assign bist_timeout = tmo_q;
`else
   assign bist_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_aes_bist_engine.sv
// Scoreboard bench for aes_bist_engine: stimulus queues expected words and run results, a monitor pops and compares.
module tb_aes_bist_engine;

   typedef struct packed {
      logic [7:0] k;
      logic [7:0] d;
   } word_t;

   typedef struct packed {
      logic [7:0] sig;
      logic       pass;
      logic       tmo;
   } res_t;

   function automatic logic [7:0] lfsr_step(input logic [7:0] q);
      return {q[6:0], ^(q & 8'h63)};
   endfunction

   // Loopback signature: MISR fed with data LFSR words (xor mask) for n cycles from seed 0x0F.
   function automatic logic [7:0] model_sig(input logic [7:0] mask, input int n);
      logic [7:0] d;
      logic [7:0] s;
      d = 8'h0F;
      s = 8'h00;
      for (int i = 0; i < n; i++) begin
         s = {s[6:0], ^(s & 8'h63)} ^ (d ^ mask);
         d = lfsr_step(d);
      end
      return s;
   endfunction

   localparam logic [7:0] GOLD = model_sig(8'h00, 16);

   logic       clk = 1'b0;
   logic       rst, is_bist, bist_start, bist_abort, dut_vld, dut_done, loop_en;
   logic [7:0] key_in, d_in, dout_drv, dout_mask;
   logic [7:0] key_to_dut, data_to_dut, d_out, signature, dut_dout;
   logic       bist_busy, bist_done, bist_pass, bist_timeout;

   always #5 clk = ~clk;

   assign dut_dout = loop_en ? (data_to_dut ^ dout_mask) : dout_drv;

   aes_bist_engine #(
      .GOLDEN_SIG    (GOLD),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .is_bist     (is_bist),
      .bist_start  (bist_start),
      .bist_abort  (bist_abort),
      .key_in      (key_in),
      .d_in        (d_in),
      .key_to_dut  (key_to_dut),
      .data_to_dut (data_to_dut),
      .dut_dout    (dut_dout),
      .dut_vld     (dut_vld),
      .dut_done    (dut_done),
      .d_out       (d_out),
      .bist_busy   (bist_busy),
      .bist_done   (bist_done),
      .bist_pass   (bist_pass),
      .bist_timeout(bist_timeout),
      .signature   (signature)
   );

   int    n_tests = 0;
   int    n_fail  = 0;
   word_t wq[$];
   res_t  rq[$];
   logic  done_prev = 1'b0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: checks each presented stimulus word and each completed run.
   initial begin
      word_t w;
      res_t  r;
      forever begin
         @(negedge clk);
         #1;
         if (rst === 1'b1) begin
            if (dut_vld) begin
               if (wq.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL word_queue: DUT word %02h/%02h with nothing expected", key_to_dut, data_to_dut);
               end else begin
                  w = wq.pop_front();
                  chk("word_key", key_to_dut, w.k);
                  chk("word_data", data_to_dut, w.d);
               end
            end
            if (bist_done && !done_prev) begin
               if (rq.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL result_queue: bist_done rose with nothing expected");
               end else begin
                  r = rq.pop_front();
                  chk("res_signature", signature, r.sig);
                  chk("res_d_out", d_out, r.sig);
                  chk("res_pass", {7'd0, bist_pass}, {7'd0, r.pass});
                  chk("res_timeout", {7'd0, bist_timeout}, {7'd0, r.tmo});
                  chk("res_busy", {7'd0, bist_busy}, 8'd0);
               end
            end
            done_prev = bist_done;
         end
      end
   end

   // One BIST run. abort_at>=0 aborts on that DRIVE cycle; done_at=0 never pulses dut_done.
   task automatic run(input logic [7:0] mask, input int abort_at, input bit abort_isb, input int done_at);
      logic [7:0] k, d;
      int         nw;
      word_t      w;
      res_t       r;
      logic       got;
      k  = 8'hA5;
      d  = 8'h0F;
      nw = (abort_at >= 0) ? abort_at : 16;
      for (int i = 0; i < nw; i++) begin
         w.k = k;
         w.d = d;
         wq.push_back(w);
         k = lfsr_step(k);
         d = lfsr_step(d);
      end
      if (abort_at < 0) begin
         r.sig  = model_sig(mask, 16);
         r.tmo  = (done_at == 0);
         r.pass = !r.tmo && (r.sig == GOLD);
         rq.push_back(r);
      end
      dout_mask = mask;
      @(negedge clk);
      bist_start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      for (int c = 0; c < 16; c++) begin
         if (c == abort_at) begin
            dut_vld = 1'b0;
            if (abort_isb) is_bist = 1'b0;
            else bist_abort = 1'b1;
            @(negedge clk);
            bist_abort = 1'b0;
            is_bist    = 1'b1;
            bist_start = 1'b0;
            chk("abort_busy", {7'd0, bist_busy}, 8'd0);
            chk("abort_done", {7'd0, bist_done}, 8'd0);
            chk("abort_sig_hold", signature, model_sig(mask, abort_at));
            return;
         end
         dut_vld = 1'b1;
         if (c == 1) begin
            chk("drive1_key", key_to_dut, 8'h4A);
            chk("drive1_data", data_to_dut, 8'h1E);
         end
         @(negedge clk);
      end
      dut_vld = 1'b0;
      got     = 1'b0;
      for (int dc = 1; dc <= 20 && !got; dc++) begin
         if (dc == done_at) dut_done = 1'b1;
         if (dc == 2) begin
            chk("drain_key_hold", key_to_dut, k);
            chk("drain_data_hold", data_to_dut, d);
         end
         @(negedge clk);
         dut_done = 1'b0;
         got      = bist_done;
      end
      chk("run_done", {7'd0, got}, 8'd1);
      bist_start = 1'b0;
   endtask

   initial begin
      rst        = 1'b0;
      is_bist    = 1'b1;
      bist_start = 1'b0;
      bist_abort = 1'b0;
      dut_vld    = 1'b0;
      dut_done   = 1'b0;
      loop_en    = 1'b1;
      dout_mask  = 8'h00;
      key_in     = 8'h11;
      d_in       = 8'h22;
      dout_drv   = 8'h33;

      repeat (4) begin
         @(negedge clk);
         bist_start = ~bist_start;
         dut_vld    = ~dut_vld;
         dut_done   = ~dut_done;
      end
      #2;
      chk("rst_busy", {7'd0, bist_busy}, 8'd0);
      chk("rst_done", {7'd0, bist_done}, 8'd0);
      chk("rst_pass", {7'd0, bist_pass}, 8'd0);
      chk("rst_timeout", {7'd0, bist_timeout}, 8'd0);
      chk("rst_signature", signature, 8'h00);
      chk("rst_key_seed", key_to_dut, 8'hA5);
      chk("rst_data_seed", data_to_dut, 8'h0F);

      @(negedge clk);
      rst        = 1'b1;
      bist_start = 1'b0;
      dut_vld    = 1'b0;
      dut_done   = 1'b0;

      @(negedge clk);
      is_bist  = 1'b0;
      loop_en  = 1'b0;
      key_in   = 8'h3C;
      d_in     = 8'h5A;
      dout_drv = 8'h77;
      #2;
      chk("pass_key", key_to_dut, 8'h3C);
      chk("pass_data", data_to_dut, 8'h5A);
      chk("pass_dout", d_out, 8'h77);
      @(negedge clk);
      is_bist = 1'b1;
      loop_en = 1'b1;

      run(8'h00, -1, 1'b0, 3);
      run(8'hFF, -1, 1'b0, 3);
      run(8'h00, 5, 1'b0, 3);
      run(8'h00, -1, 1'b0, 3);
      run(8'h00, 3, 1'b1, 3);
      run(8'h00, -1, 1'b0, 3);
`ifdef BIST_TIMEOUT_EN
      run(8'h00, -1, 1'b0, 0);
      run(8'h00, -1, 1'b0, 8);
`endif
      repeat (3) @(negedge clk);
      chk("words_left", 8'(wq.size()), 8'd0);
      chk("results_left", 8'(rq.size()), 8'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
